apb_bcast_crossbar: RTL and testbench

Parametrised, buffered successor to the single-cycle APB interconnect. It routes master words to slaves by destination address, either unicast to one slave or broadcast on one of several channels to every subscribed slave. Each master gets a one-deep holding slot with ready backpressure. Each slave has a round-robin arbiter and a registered valid/ready output. The block sits between the master-side producers and the slave-side consumers on the `pclk` domain.

---
 rtl/apb_ic_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/apb_bcast_crossbar.sv | 161 ++++++++++++++++
 tb/tb_apb_bcast_crossbar.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_ic_pkg.sv
// Shared constants and types for the broadcast APB crossbar.
// Index-width helper, drop-counter sizing and the default slot layout.
package apb_ic_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // Width of an index into n items, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_MASTERS = 8;
    localparam int DEF_NUM_SLAVES  = 4;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_MST_IDX_W   = idx_w(DEF_NUM_MASTERS);

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_NUM_SLAVES-1:0] mask;
        logic [DEF_MST_IDX_W-1:0]  src;
    } slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter
    import apb_ic_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grant_idx,
    output logic         o_any
);

    logic [N-1:0][W-1:0] w_order;
    logic [N-1:0]        w_hit;

    // Visiting order starting at the pointer
    always_comb begin
        w_order = '0;
        for (int k = 0; k < N; k++) begin
            w_order[k] = W'((int'(i_ptr) + k) % N);
        end
    end

    // First requester in visiting order wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_hit       = '0;
        for (int k = 0; k < N; k++) begin
            w_hit[k]             = !o_any && i_req[w_order[k]];
            o_grant[w_order[k]]  = o_grant[w_order[k]] | w_hit[k];
            o_grant_idx          = w_hit[k] ? w_order[k] : o_grant_idx;
            o_any                = o_any | w_hit[k];
        end
    end

endmodule

// File: rtl/apb_bcast_crossbar.sv
// Buffered crossbar: one holding slot per master, unicast or broadcast
// delivery, round-robin registered output per slave, saturating drop counter.
module apb_bcast_crossbar
    import apb_ic_pkg::*;
#(
    parameter int NUM_MASTERS = 8,
    parameter int NUM_SLAVES  = 4,
    parameter int NUM_BCAST   = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    localparam int MIW = idx_w(NUM_MASTERS)
) (
    input  logic                                    pclk,
    input  logic                                    reset,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  master_data,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  dest_addrs,
    input  logic [NUM_MASTERS-1:0]                  master_valids,
    output logic [NUM_MASTERS-1:0]                  master_readys,
    input  logic [NUM_SLAVES-1:0][NUM_BCAST-1:0]    src_brdcst_subscription,
    output logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]   slave_data,
    output logic [NUM_SLAVES-1:0][MIW-1:0]          slave_src,
    output logic [NUM_SLAVES-1:0]                   slave_valids,
    input  logic [NUM_SLAVES-1:0]                   slave_readys,
    output logic [CNT_W-1:0]                        drop_count
);

    localparam int SUM_W = CNT_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [NUM_SLAVES-1:0] mask;
        logic [MIW-1:0]        src;
    } mslot_t;

    mslot_t r_slot [NUM_MASTERS];

    logic [NUM_MASTERS-1:0][NUM_SLAVES-1:0]  w_dec_mask;
    logic [NUM_MASTERS-1:0][NUM_SLAVES-1:0]  w_clr;
    logic [NUM_MASTERS-1:0]                  w_accept;
    logic [NUM_MASTERS-1:0]                  w_drop;
    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  w_req;
    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  w_gnt;
    logic [NUM_SLAVES-1:0][MIW-1:0]          w_gnt_idx;
    logic [NUM_SLAVES-1:0][MIW-1:0]          r_rr_ptr;
    logic [NUM_SLAVES-1:0]                   w_any;
    logic [NUM_SLAVES-1:0]                   w_fire;
    logic [SUM_W-1:0]                        w_drop_sum;

    // A slot is free when nothing is left to deliver; reset blocks acceptance
    always_comb begin
        master_readys = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            master_readys[m] = !reset && (r_slot[m].mask == '0);
        end
    end

    // Destination decode; the subscription is only consulted here, at acceptance
    always_comb begin
        w_dec_mask = '0;
        w_accept   = '0;
        w_drop     = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                w_dec_mask[m][s] = (dest_addrs[m] == ADDR_WIDTH'(s));
                for (int c = 0; c < NUM_BCAST; c++) begin
                    w_dec_mask[m][s] = w_dec_mask[m][s] |
                        ((dest_addrs[m] == ADDR_WIDTH'(NUM_SLAVES + c)) &&
                         src_brdcst_subscription[s][c]);
                end
            end
            w_accept[m] = master_valids[m] && master_readys[m];
            w_drop[m]   = w_accept[m] && (w_dec_mask[m] == '0);
        end
    end

    // Transpose pending masks into per-slave request vectors and grant clears
    always_comb begin
        w_req = '0;
        w_clr = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            w_fire[s] = w_any[s] && (!slave_valids[s] || slave_readys[s]);
            for (int m = 0; m < NUM_MASTERS; m++) begin
                w_req[s][m] = r_slot[m].mask[s];
                w_clr[m][s] = w_fire[s] && w_gnt[s][m];
            end
        end
    end

    for (genvar gs = 0; gs < NUM_SLAVES; gs++) begin : g_slv
        rr_arbiter #(.N(NUM_MASTERS)) u_arb (
            .i_req       (w_req[gs]),
            .i_ptr       (r_rr_ptr[gs]),
            .o_grant     (w_gnt[gs]),
            .o_grant_idx (w_gnt_idx[gs]),
            .o_any       (w_any[gs])
        );
    end

    // Master slots: load on acceptance, retire mask bits as slaves take the word
    always_ff @(posedge pclk) begin
        if (reset) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                r_slot[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (w_accept[m]) begin
                    r_slot[m].data <= master_data[m];
                    r_slot[m].mask <= w_dec_mask[m];
                    r_slot[m].src  <= MIW'(m);
                end else begin
                    r_slot[m].mask <= r_slot[m].mask & ~w_clr[m];
                end
            end
        end
    end

    // Slave output registers and round-robin pointers
    always_ff @(posedge pclk) begin
        if (reset) begin
            slave_valids <= '0;
            slave_data   <= '0;
            slave_src    <= '0;
            r_rr_ptr     <= '0;
        end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (w_fire[s]) begin
                    slave_data[s]   <= r_slot[w_gnt_idx[s]].data;
                    slave_src[s]    <= r_slot[w_gnt_idx[s]].src;
                    slave_valids[s] <= 1'b1;
                    r_rr_ptr[s]     <= (w_gnt_idx[s] == MIW'(NUM_MASTERS - 1)) ?
                                       '0 : w_gnt_idx[s] + 1'b1;
                end else if (slave_readys[s]) begin
                    slave_valids[s] <= 1'b0;
                end else begin
                    slave_valids[s] <= slave_valids[s];
                end
            end
        end
    end

    // Add this cycle's drops; the extra sum bit flags saturation
    always_comb begin
        w_drop_sum = {1'b0, drop_count};
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_drop_sum = w_drop_sum + SUM_W'(w_drop[m]);
        end
    end

    // Saturating drop counter
    always_ff @(posedge pclk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (w_drop_sum[CNT_W]) begin
            drop_count <= CNT_MAX;
        end else begin
            drop_count <= w_drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_apb_bcast_crossbar.sv
// Directed bench for apb_bcast_crossbar with hand-computed expectations.
module tb_apb_bcast_crossbar;

    logic              pclk;
    logic              reset;
    logic [7:0][31:0]  master_data;
    logic [7:0][2:0]   dest_addrs;
    logic [7:0]        master_valids;
    logic [7:0]        master_readys;
    logic [3:0][1:0]   src_brdcst_subscription;
    logic [3:0][31:0]  slave_data;
    logic [3:0][2:0]   slave_src;
    logic [3:0]        slave_valids;
    logic [3:0]        slave_readys;
    logic [15:0]       drop_count;

    int n_vec = 0;
    int n_mis = 0;

    apb_bcast_crossbar dut (
        .pclk                    (pclk),
        .reset                   (reset),
        .master_data             (master_data),
        .dest_addrs              (dest_addrs),
        .master_valids           (master_valids),
        .master_readys           (master_readys),
        .src_brdcst_subscription (src_brdcst_subscription),
        .slave_data              (slave_data),
        .slave_src               (slave_src),
        .slave_valids            (slave_valids),
        .slave_readys            (slave_readys),
        .drop_count              (drop_count)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset                   = 1'b1;
        master_data             = '0;
        dest_addrs              = '0;
        master_valids           = 8'hFF;
        src_brdcst_subscription = '0;
        slave_readys            = 4'hF;

        // 1: reset held with all masters requesting
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_mready", master_readys, 8'h00);
            chk("rst_svalid", slave_valids, 4'h0);
            chk("rst_drop", drop_count, 16'h0000);
        end
        reset         = 1'b0;
        master_valids = 8'h00;
        #1;
        chk("rel_mready", master_readys, 8'hFF);

        // 2: unicast master 2 -> slave 1
        master_data[2]  = 32'hDEADBEEF;
        dest_addrs[2]   = 3'd1;
        master_valids   = 8'h04;
        tick();
        master_valids   = 8'h00;
        chk("uc_mready_low", master_readys, 8'hFB);
        chk("uc_svalid_t0", slave_valids, 4'h0);
        tick();
        chk("uc_svalid", slave_valids, 4'b0010);
        chk("uc_sdata", slave_data[1], 32'hDEADBEEF);
        chk("uc_ssrc", slave_src[1], 32'd2);
        chk("uc_mready_back", master_readys, 8'hFF);
        tick();
        chk("uc_drained", slave_valids, 4'h0);

        // 3: masters 0,3,5 contend for slave 0
        dest_addrs    = '0;
        master_data[0] = 32'h100;
        master_data[3] = 32'h300;
        master_data[5] = 32'h500;
        master_valids  = 8'b0010_1001;
        tick();
        master_valids  = 8'h00;
        tick();
        chk("rr_src0", slave_src[0], 32'd0);
        chk("rr_data0", slave_data[0], 32'h100);
        chk("rr_mready0", master_readys, 8'hD7);
        tick();
        chk("rr_src3", slave_src[0], 32'd3);
        chk("rr_data3", slave_data[0], 32'h300);
        tick();
        chk("rr_src5", slave_src[0], 32'd5);
        chk("rr_valid5", slave_valids, 4'b0001);
        chk("rr_mready_all", master_readys, 8'hFF);
        // pointer now 6: master 0 must beat master 1
        master_data[0] = 32'hA0;
        master_data[1] = 32'hA1;
        master_valids  = 8'b0000_0011;
        tick();
        master_valids  = 8'h00;
        chk("rr_gap", slave_valids, 4'h0);
        tick();
        chk("rr_wrap_src0", slave_src[0], 32'd0);
        chk("rr_wrap_data0", slave_data[0], 32'hA0);
        tick();
        chk("rr_wrap_src1", slave_src[0], 32'd1);
        tick();
        chk("rr_wrap_idle", slave_valids, 4'h0);

        // 4: broadcast channel 0 to slaves 0 and 2, slave 2 stalled
        slave_readys   = 4'b1011;
        master_data[7] = 32'h77;
        dest_addrs[7]  = 3'd2;
        master_valids  = 8'h80;
        tick();
        master_valids  = 8'h00;
        tick();
        chk("bc_pre_valid", slave_valids, 4'b0100);
        chk("bc_pre_data2", slave_data[2], 32'h77);
        src_brdcst_subscription = 8'h11;
        master_data[1] = 32'hB1;
        dest_addrs[1]  = 3'd4;
        master_valids  = 8'h02;
        tick();
        master_valids  = 8'h00;
        chk("bc_acc_mready", master_readys, 8'hFD);
        tick();
        chk("bc_s0_valid", slave_valids, 4'b0101);
        chk("bc_s0_data", slave_data[0], 32'hB1);
        chk("bc_s2_held", slave_data[2], 32'h77);
        chk("bc_mready_wait", master_readys, 8'hFD);
        tick();
        chk("bc_s0_drained", slave_valids, 4'b0100);
        tick();
        chk("bc_still_wait", master_readys, 8'hFD);
        src_brdcst_subscription = '0;
        slave_readys = 4'hF;
        tick();
        chk("bc_s2_data", slave_data[2], 32'hB1);
        chk("bc_s2_src", slave_src[2], 32'd1);
        chk("bc_s2_valid", slave_valids, 4'b0100);
        chk("bc_mready_free", master_readys, 8'hFF);
        tick();
        chk("bc_idle", slave_valids, 4'h0);

        // 5: invalid address and empty broadcast in the same cycle
        dest_addrs[4] = 3'd7;
        dest_addrs[6] = 3'd5;
        master_valids = 8'b0101_0000;
        tick();
        master_valids = 8'h00;
        chk("drop_two", drop_count, 16'd2);
        chk("drop_mready", master_readys, 8'hFF);
        tick();
        chk("drop_no_valid", slave_valids, 4'h0);
        chk("drop_hold", drop_count, 16'd2);
        for (int m = 0; m < 8; m++) dest_addrs[m] = 3'd7;
        master_valids = 8'hFF;
        for (int i = 0; i < 8191; i++) tick();
        chk("drop_near_sat", drop_count, 16'hFFFA);
        tick();
        chk("drop_sat", drop_count, 16'hFFFF);
        tick();
        chk("drop_sat_hold", drop_count, 16'hFFFF);
        master_valids = 8'h00;

        // 6: reset while slots and outputs are full
        slave_readys = 4'h0;
        for (int m = 0; m < 8; m++) begin
            dest_addrs[m]  = 3'(m % 4);
            master_data[m] = 32'h60 + 32'(m);
        end
        master_valids = 8'h0F;
        tick();
        master_valids = 8'h00;
        tick();
        chk("full_svalid", slave_valids, 4'hF);
        master_valids = 8'hF0;
        tick();
        master_valids = 8'h00;
        chk("full_mready", master_readys, 8'h0F);
        reset         = 1'b1;
        master_valids = 8'hFF;
        #1;
        chk("rst_mid_mready_now", master_readys, 8'h00);
        tick();
        chk("rst_mid_svalid", slave_valids, 4'h0);
        chk("rst_mid_sdata0", slave_data[0], 32'h0);
        chk("rst_mid_drop", drop_count, 16'h0000);
        reset         = 1'b0;
        master_valids = 8'h00;
        slave_readys  = 4'hF;
        #1;
        chk("rst_mid_release", master_readys, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_stale", slave_valids, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
